// File: rtl/ctrl_pipe_decoder.sv
// Pipelined control decoder: ID capture, decode, EX/MEM/WB control staging,
// load-use stall and branch flush. Optional perf counters under CTRL_PERF_CNT_EN.
module ctrl_pipe_decoder #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_valid,
  output logic               id_ready,
  input  logic               flush,
  output logic               hazard_stall,
  output logic               illegal_op,
  output logic               ex_valid,
  output logic               mem_valid,
  output logic               wb_valid,
  output logic [15:0]        ex_ctrl,
  output logic [3:0]         mem_ctrl,
  output logic [3:0]         mem_xfer_size,
  output logic [1:0]         wb_ctrl,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [REG_AW-1:0]  mem_rd,
  output logic [REG_AW-1:0]  wb_rd
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   illegal_cnt
`endif
);

  // Handshake: an instruction moves from fetch into ID on a rising edge where
  // if_valid && id_ready; fetch must hold if_instr while id_ready is low.

  localparam logic [REG_AW-1:0] XZR = '1;

  localparam int C_REG2LOC = 15;
  localparam int C_ALUSRC  = 14;
  localparam int C_ISADDI  = 10;
  localparam int C_ISLSR   = 9;
  localparam int C_FLAGEN  = 8;
  localparam int C_UNCOND  = 7;
  localparam int C_MEMW    = 6;
  localparam int C_RDEN    = 5;
  localparam int C_M2R     = 4;
  localparam int C_REGW    = 3;

  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_EOR = 3'b110;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b000;

  // ID stage register: only the fields decode and hazard logic consume
  logic              id_valid;
  logic [10:0]       id_op;
  logic [REG_AW-1:0] id_rm;
  logic [REG_AW-1:0] id_rn;
  logic [REG_AW-1:0] id_rd;

  logic [5:0] instr_unused;
  assign instr_unused = if_instr[15:10];

  // Decode outputs
  logic [15:0] dec_ctrl;
  logic [3:0]  dec_xfer;
  logic        dec_known;
  logic        dec_use_rm;
  logic        dec_use_rt;

  always_comb begin
    dec_ctrl   = '0;
    dec_xfer   = '0;
    dec_known  = 1'b0;
    dec_use_rm = 1'b0;
    dec_use_rt = 1'b0;
    casez (id_op)
      11'b10001010000: begin
        dec_known = 1'b1; dec_use_rm = 1'b1;
        dec_ctrl[C_REG2LOC] = 1'b1; dec_ctrl[13:11] = ALU_AND; dec_ctrl[C_REGW] = 1'b1;
      end
      11'b10101011000: begin
        dec_known = 1'b1; dec_use_rm = 1'b1;
        dec_ctrl[C_REG2LOC] = 1'b1; dec_ctrl[13:11] = ALU_ADD;
        dec_ctrl[C_FLAGEN] = 1'b1; dec_ctrl[C_REGW] = 1'b1;
      end
      11'b11001010000: begin
        dec_known = 1'b1; dec_use_rm = 1'b1;
        dec_ctrl[C_REG2LOC] = 1'b1; dec_ctrl[13:11] = ALU_EOR; dec_ctrl[C_REGW] = 1'b1;
      end
      11'b11101011000: begin
        dec_known = 1'b1; dec_use_rm = 1'b1;
        dec_ctrl[C_REG2LOC] = 1'b1; dec_ctrl[13:11] = ALU_SUB;
        dec_ctrl[C_FLAGEN] = 1'b1; dec_ctrl[C_REGW] = 1'b1;
      end
      11'b1001000100?: begin
        dec_known = 1'b1;
        dec_ctrl[C_ALUSRC] = 1'b1; dec_ctrl[13:11] = ALU_ADD;
        dec_ctrl[C_ISADDI] = 1'b1; dec_ctrl[C_REGW] = 1'b1;
      end
      11'b11111000010: begin
        dec_known = 1'b1; dec_xfer = 4'd8;
        dec_ctrl[C_ALUSRC] = 1'b1; dec_ctrl[13:11] = ALU_ADD; dec_ctrl[C_RDEN] = 1'b1;
        dec_ctrl[C_M2R] = 1'b1; dec_ctrl[C_REGW] = 1'b1;
      end
      11'b11111000000: begin
        dec_known = 1'b1; dec_use_rt = 1'b1; dec_xfer = 4'd8;
        dec_ctrl[C_ALUSRC] = 1'b1; dec_ctrl[13:11] = ALU_ADD; dec_ctrl[C_MEMW] = 1'b1;
      end
      11'b10110100???: begin
        dec_known = 1'b1; dec_use_rt = 1'b1;
        dec_ctrl[13:11] = ALU_PASS; dec_ctrl[C_FLAGEN] = 1'b1;
      end
      11'b01010100???: begin
        dec_known = 1'b1;
      end
      11'b000101?????: begin
        dec_known = 1'b1; dec_ctrl[C_UNCOND] = 1'b1;
      end
      11'b11010011010: begin
        dec_known = 1'b1;
        dec_ctrl[13:11] = ALU_PASS; dec_ctrl[C_ISLSR] = 1'b1; dec_ctrl[C_REGW] = 1'b1;
      end
      default: begin
        dec_known = 1'b0;
      end
    endcase
  end

  // EX stage register
  logic [15:0]       ex_ctrl_q;
  logic [3:0]        ex_xfer_q;
  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_rd_q;

  // Second source is rm for R-type, rt (the [4:0] field) for STUR/CBZ
  logic [REG_AW-1:0] id_src2;
  logic              id_src2_en;
  logic              id_live;

  assign id_src2    = dec_use_rm ? id_rm : id_rd;
  assign id_src2_en = dec_use_rm | dec_use_rt;
  assign id_live    = id_valid & dec_known;

  always_comb begin
    hazard_stall = 1'b0;
    if (!flush && ex_valid_q && ex_ctrl_q[C_RDEN] && (ex_rd_q != XZR) && id_live) begin
      hazard_stall = (ex_rd_q == id_rn) | (id_src2_en & (ex_rd_q == id_src2));
    end
  end

  assign id_ready   = ~hazard_stall;
  assign illegal_op = id_valid & ~dec_known;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_op    <= '0;
      id_rm    <= '0;
      id_rn    <= '0;
      id_rd    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_op    <= '0;
      id_rm    <= '0;
      id_rn    <= '0;
      id_rd    <= '0;
    end else if (!hazard_stall) begin
      id_valid <= if_valid;
      if (if_valid) begin
        id_op <= if_instr[31:21];
        id_rm <= if_instr[20:16];
        id_rn <= if_instr[9:5];
        id_rd <= if_instr[4:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_xfer_q  <= '0;
      ex_rd_q    <= '0;
    end else if (flush || hazard_stall || !id_live) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_xfer_q  <= '0;
      ex_rd_q    <= '0;
    end else begin
      ex_valid_q <= 1'b1;
      ex_ctrl_q  <= dec_ctrl;
      ex_xfer_q  <= dec_xfer;
      ex_rd_q    <= id_rd;
    end
  end

  // MEM and WB always advance, even across stalls and flushes
  logic              mem_valid_q;
  logic              mem_write_q;
  logic              mem_read_q;
  logic              mem_m2r_q;
  logic              mem_regw_q;
  logic [3:0]        mem_xfer_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_valid_q;
  logic [1:0]        wb_ctrl_q;
  logic [REG_AW-1:0] wb_rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_m2r_q   <= 1'b0;
      mem_regw_q  <= 1'b0;
      mem_xfer_q  <= '0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_write_q <= ex_ctrl_q[C_MEMW];
      mem_read_q  <= ex_ctrl_q[C_RDEN];
      mem_m2r_q   <= ex_ctrl_q[C_M2R];
      mem_regw_q  <= ex_ctrl_q[C_REGW];
      mem_xfer_q  <= ex_xfer_q;
      mem_rd_q    <= ex_rd_q;
      wb_valid_q  <= mem_valid_q;
      wb_ctrl_q   <= {mem_m2r_q, mem_regw_q};
      wb_rd_q     <= mem_rd_q;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_ctrl       = ex_ctrl_q;
  assign ex_rd         = ex_rd_q;
  assign mem_valid     = mem_valid_q;
  assign mem_ctrl      = {mem_write_q, mem_read_q, mem_xfer_q[1:0]};
  assign mem_xfer_size = mem_xfer_q;
  assign mem_rd        = mem_rd_q;
  assign wb_valid      = wb_valid_q;
  assign wb_ctrl       = wb_ctrl_q;
  assign wb_rd         = wb_rd_q;

`ifdef CTRL_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (hazard_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (illegal_op && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Directed bench for ctrl_pipe_decoder: reset, decode table, load-use stall,
// XZR exemption, flush over stall, illegal opcode and mid-stream reset.
module tb_ctrl_pipe_decoder;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [INSTR_W-1:0] if_instr = '0;
  logic               if_valid = 1'b0;
  logic               flush = 1'b0;
  logic               id_ready, hazard_stall, illegal_op;
  logic               ex_valid, mem_valid, wb_valid;
  logic [15:0]        ex_ctrl;
  logic [3:0]         mem_ctrl, mem_xfer_size;
  logic [1:0]         wb_ctrl;
  logic [REG_AW-1:0]  ex_rd, mem_rd, wb_rd;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0]   stall_cnt, flush_cnt, illegal_cnt;
`endif

  ctrl_pipe_decoder #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_valid(if_valid),
    .id_ready(id_ready), .flush(flush), .hazard_stall(hazard_stall),
    .illegal_op(illegal_op), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .mem_xfer_size(mem_xfer_size), .wb_ctrl(wb_ctrl), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .wb_rd(wb_rd)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] I_ADDS   = 32'hAB030041; // ADDS X1,X2,X3
  localparam logic [31:0] I_LDUR5  = 32'hF8400025; // LDUR X5,[X1,#0]
  localparam logic [31:0] I_AND652 = 32'h8A0200A6; // AND X6,X5,X2
  localparam logic [31:0] I_LDUR31 = 32'hF840003F; // LDUR X31,[X1,#0]
  localparam logic [31:0] I_AND_ZR = 32'h8A0203E6; // AND X6,X31,X2
  localparam logic [31:0] I_STUR5  = 32'hF8000025; // STUR X5,[X1,#0]

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change at the falling edge, outputs sampled there
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] instr, input logic vld);
    if_instr = instr;
    if_valid = vld;
  endtask

  task automatic drain();
    drive('0, 1'b0);
    repeat (4) cyc();
  endtask

  logic [31:0] tbl_instr [10];
  logic [15:0] tbl_ctrl  [10];
  logic        tbl_vld   [10];

  initial begin
    tbl_instr[0] = 32'hF8000000; tbl_ctrl[0] = 16'h5040; tbl_vld[0] = 1'b1; // STUR
    tbl_instr[1] = 32'h91000000; tbl_ctrl[1] = 16'h5408; tbl_vld[1] = 1'b1; // ADDI
    tbl_instr[2] = 32'h91200000; tbl_ctrl[2] = 16'h5408; tbl_vld[2] = 1'b1; // ADDI, opcode lsb set
    tbl_instr[3] = 32'hCA000000; tbl_ctrl[3] = 16'hB008; tbl_vld[3] = 1'b1; // EOR
    tbl_instr[4] = 32'hEB000000; tbl_ctrl[4] = 16'h9908; tbl_vld[4] = 1'b1; // SUBS
    tbl_instr[5] = 32'hB4000000; tbl_ctrl[5] = 16'h0100; tbl_vld[5] = 1'b1; // CBZ
    tbl_instr[6] = 32'h54000000; tbl_ctrl[6] = 16'h0000; tbl_vld[6] = 1'b1; // B.cond
    tbl_instr[7] = 32'h14000000; tbl_ctrl[7] = 16'h0080; tbl_vld[7] = 1'b1; // B
    tbl_instr[8] = 32'hD3400000; tbl_ctrl[8] = 16'h0208; tbl_vld[8] = 1'b1; // LSR
    tbl_instr[9] = 32'hF8200000; tbl_ctrl[9] = 16'h0000; tbl_vld[9] = 1'b0; // unknown near LDUR

    // reset state
    repeat (2) cyc();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_id_ready", id_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_illegal", illegal_op, 0);
    reset = 1'b1;
    cyc();

    // ADDS flows through the pipe
    drive(I_ADDS, 1'b1);
    cyc();
    drive('0, 1'b0);
    check("adds_id_ex_valid", ex_valid, 0);
    check("adds_id_illegal", illegal_op, 0);
    cyc();
    check("adds_ex_valid", ex_valid, 1);
    check("adds_ex_ctrl", ex_ctrl, 16'h9108);
    check("adds_ex_rd", ex_rd, 1);
    cyc();
    check("adds_mem_valid", mem_valid, 1);
    check("adds_mem_ctrl", mem_ctrl, 0);
    check("adds_mem_xfer", mem_xfer_size, 0);
    check("adds_mem_rd", mem_rd, 1);
    check("adds_ex_empty", ex_valid, 0);
    cyc();
    check("adds_wb_valid", wb_valid, 1);
    check("adds_wb_ctrl", wb_ctrl, 2'b01);
    check("adds_wb_rd", wb_rd, 1);
    drain();

    // load-use: LDUR X5 then AND X6,X5,X2
    drive(I_LDUR5, 1'b1);
    cyc();
    drive(I_AND652, 1'b1);
    check("lu_pre_stall", hazard_stall, 0);
    cyc();
    check("lu_stall", hazard_stall, 1);
    check("lu_id_ready", id_ready, 0);
    check("lu_ex_ctrl", ex_ctrl, 16'h5038);
    check("lu_ex_rd", ex_rd, 5);
    drive('0, 1'b0);
    cyc();
    check("lu_stall_done", hazard_stall, 0);
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", ex_ctrl, 0);
    check("lu_mem_valid", mem_valid, 1);
    check("lu_mem_ctrl", mem_ctrl, 4'b0100);
    check("lu_mem_xfer", mem_xfer_size, 8);
    check("lu_mem_rd", mem_rd, 5);
    cyc();
    check("lu_and_ex_valid", ex_valid, 1);
    check("lu_and_ex_ctrl", ex_ctrl, 16'hA008);
    check("lu_and_ex_rd", ex_rd, 6);
    check("lu_ldur_wb_ctrl", wb_ctrl, 2'b11);
    check("lu_ldur_wb_rd", wb_rd, 5);
    drain();

    // load to XZR never stalls
    drive(I_LDUR31, 1'b1);
    cyc();
    drive(I_AND_ZR, 1'b1);
    cyc();
    check("xzr_no_stall", hazard_stall, 0);
    check("xzr_id_ready", id_ready, 1);
    drive('0, 1'b0);
    cyc();
    check("xzr_and_ex_valid", ex_valid, 1);
    check("xzr_and_ex_ctrl", ex_ctrl, 16'hA008);
    drain();

    // STUR data register (rt) also creates a load-use hazard
    drive(I_LDUR5, 1'b1);
    cyc();
    drive(I_STUR5, 1'b1);
    cyc();
    check("rt_stall", hazard_stall, 1);
    drain();

    // flush during a stall: ADDS, LDUR X5, AND X6,X5,X2
    drive(I_ADDS, 1'b1);
    cyc();
    drive(I_LDUR5, 1'b1);
    cyc();
    drive(I_AND652, 1'b1);
    cyc();
    check("fl_stall_before", hazard_stall, 1);
    drive('0, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_stall_forced", hazard_stall, 0);
    check("fl_id_ready", id_ready, 1);
    cyc();
    flush = 1'b0;
    check("fl_ex_valid", ex_valid, 0);
    check("fl_ex_ctrl", ex_ctrl, 0);
    check("fl_mem_valid", mem_valid, 1);
    check("fl_mem_rd", mem_rd, 5);
    check("fl_wb_valid", wb_valid, 1);
    check("fl_wb_rd", wb_rd, 1);
    check("fl_wb_ctrl", wb_ctrl, 2'b01);
    cyc();
    check("fl_id_killed", ex_valid, 0);
    check("fl_mem_empty", mem_valid, 0);
    check("fl_wb_ldur_rd", wb_rd, 5);
    check("fl_wb_ldur_ctrl", wb_ctrl, 2'b11);
    drain();

    // illegal opcode 0x000
    drive(32'h0000_0000, 1'b1);
    cyc();
    check("ill_pulse", illegal_op, 1);
    drive('0, 1'b0);
    cyc();
    check("ill_pulse_end", illegal_op, 0);
    check("ill_ex_valid", ex_valid, 0);
    check("ill_ex_ctrl", ex_ctrl, 0);
`ifdef CTRL_PERF_CNT_EN
    check("ill_cnt", illegal_cnt, 1);
`endif
    drain();

    // remaining opcodes
    for (int i = 0; i < 10; i++) begin
      drive(tbl_instr[i], 1'b1);
      cyc();
      drive('0, 1'b0);
      cyc();
      check($sformatf("tbl%0d_ex_valid", i), ex_valid, tbl_vld[i]);
      check($sformatf("tbl%0d_ex_ctrl", i), ex_ctrl, tbl_ctrl[i]);
    end
    drain();
`ifdef CTRL_PERF_CNT_EN
    check("cnt_stall", stall_cnt, 2);
    check("cnt_flush", flush_cnt, 1);
    check("cnt_illegal", illegal_cnt, 2);
`endif

    // asynchronous reset with ADDS in EX
    drive(I_ADDS, 1'b1);
    cyc();
    cyc();
    check("ar_pre_ex_valid", ex_valid, 1);
    reset = 1'b0;
    #1;
    check("ar_ex_valid", ex_valid, 0);
    check("ar_ex_ctrl", ex_ctrl, 0);
    check("ar_ex_rd", ex_rd, 0);
    check("ar_mem_valid", mem_valid, 0);
    check("ar_id_ready", id_ready, 1);
    check("ar_illegal", illegal_op, 0);
`ifdef CTRL_PERF_CNT_EN
    check("ar_stall_cnt", stall_cnt, 0);
    check("ar_illegal_cnt", illegal_cnt, 0);
`endif
    drive('0, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    check("ar_after_ex_valid", ex_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
